// File: rtl/stream_demux_dispatch.sv
// Registered 1xN stream dispatcher: one output register per channel, valid/ready per channel.
// Optional saturating drop counter enabled by defining STREAM_DEMUX_DROP_CNT_EN.
module stream_demux_dispatch #(
  parameter int N         = 4,
  parameter int SEL_WIDTH = 2,
  parameter int DW        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        in_data,
  input  logic [SEL_WIDTH-1:0] in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N*DW-1:0]      out_data,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready,
  output logic                 drop_pulse,
  output logic [15:0]          drop_cnt
);

  logic in_range;
  logic accept;

  // Out-of-range selects are always accepted so they can be discarded.
  always_comb begin
    in_ready = 1'b1;
    in_range = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SEL_WIDTH'(k)) begin
        in_ready = ~out_valid[k] | out_ready[k];
        in_range = 1'b1;
      end
    end
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= '0;
      out_data   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (accept && in_sel == SEL_WIDTH'(k)) begin
          out_data[k*DW +: DW] <= in_data;
          out_valid[k]         <= 1'b1;
        end else if (out_valid[k] && out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
      drop_pulse <= accept & ~in_range;
    end
  end

`ifdef STREAM_DEMUX_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (accept && !in_range && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_demux_dispatch.sv
// Bench for stream_demux_dispatch: a 4-channel and a 3-channel instance share stimulus and are
// checked every cycle against a per-channel "word held" reference model.
module tb_stream_demux_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic [3:0]  ord;

  logic        rdy4, rdy3;
  logic [31:0] od4;
  logic [23:0] od3;
  logic [3:0]  ov4;
  logic [2:0]  ov3;
  logic        dp4, dp3;
  logic [15:0] dc4, dc3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_demux_dispatch #(.N(4), .SEL_WIDTH(2), .DW(8)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(rdy4), .out_data(od4), .out_valid(ov4), .out_ready(ord),
    .drop_pulse(dp4), .drop_cnt(dc4)
  );

  stream_demux_dispatch #(.N(3), .SEL_WIDTH(2), .DW(8)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(rdy3), .out_data(od3), .out_valid(ov3), .out_ready(ord[2:0]),
    .drop_pulse(dp3), .drop_cnt(dc3)
  );

  // Reference model: index 0 is the 4-channel instance, index 1 the 3-channel one.
  bit         m_held [2][4];
  logic [7:0] m_data [2][4];
  bit         m_pulse[2];
  int         m_cnt  [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int nch(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  function automatic bit m_ready(input int i);
    if (int'(in_sel) >= nch(i)) return 1'b1;
    return !m_held[i][in_sel] || ord[in_sel];
  endfunction

  function automatic logic [31:0] exp_valid(input int i);
    logic [31:0] v = '0;
    for (int k = 0; k < nch(i); k++) v[k] = m_held[i][k];
    return v;
  endfunction

  function automatic logic [31:0] exp_data(input int i);
    logic [31:0] v = '0;
    for (int k = 0; k < nch(i); k++) v[k*8 +: 8] = m_data[i][k];
    return v;
  endfunction

  function automatic logic [31:0] exp_cnt(input int i);
`ifdef STREAM_DEMUX_DROP_CNT_EN
    return 32'(m_cnt[i]);
`else
    return 32'(0 * i);
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin
        m_held[i][k] = 1'b0;
        m_data[i][k] = 8'h00;
      end
      m_pulse[i] = 1'b0;
      m_cnt[i]   = 0;
    end
  endtask

  // Check the current cycle at negedge, then advance the model across the next rising edge.
  task automatic step();
    bit acc[2];
    @(negedge clk);
    check_eq("in_ready4",   32'(rdy4), 32'(m_ready(0)));
    check_eq("in_ready3",   32'(rdy3), 32'(m_ready(1)));
    check_eq("out_valid4",  32'(ov4),  exp_valid(0));
    check_eq("out_valid3",  32'(ov3),  exp_valid(1));
    check_eq("out_data4",   od4,       exp_data(0));
    check_eq("out_data3",   32'(od3),  exp_data(1));
    check_eq("drop_pulse4", 32'(dp4),  32'(m_pulse[0]));
    check_eq("drop_pulse3", 32'(dp3),  32'(m_pulse[1]));
    check_eq("drop_cnt4",   32'(dc4),  exp_cnt(0));
    check_eq("drop_cnt3",   32'(dc3),  exp_cnt(1));
    for (int i = 0; i < 2; i++) acc[i] = in_valid && m_ready(i);
    if (rst) begin
      model_clear();
    end else begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < nch(i); k++) begin
          if (m_held[i][k] && ord[k]) m_held[i][k] = 1'b0;
          if (acc[i] && int'(in_sel) == k) begin
            m_held[i][k] = 1'b1;
            m_data[i][k] = in_data;
          end
        end
        m_pulse[i] = acc[i] && int'(in_sel) >= nch(i);
        if (m_pulse[i] && m_cnt[i] < 65535) m_cnt[i]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [1:0] sel, input logic [7:0] d);
    in_valid = v;
    in_sel   = sel;
    in_data  = d;
    step();
  endtask

  initial begin
    model_clear();
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd1; in_data = 8'hEE; ord = 4'hF;
    @(posedge clk);
    #1;
    // Reset held for two cycles with a valid word presented.
    send(1'b1, 2'd1, 8'hEE);
    send(1'b1, 2'd3, 8'hEF);
    rst = 1'b0;

    for (int k = 0; k < 4; k++) send(1'b1, 2'(k), 8'hA0 + 8'(k));
    send(1'b0, 2'd0, 8'h00);
    send(1'b0, 2'd0, 8'h00);

    // Backpressure on channel 2.
    ord = 4'b1011;
    send(1'b1, 2'd2, 8'h11);
    for (int c = 0; c < 3; c++) send(1'b1, 2'd2, 8'h22);
    check_eq("bp_stalled_ready", 32'(rdy4), 32'd0);
    ord = 4'hF;
    send(1'b1, 2'd2, 8'h22);
    send(1'b0, 2'd2, 8'h00);
    send(1'b0, 2'd2, 8'h00);

    // Independence: channel 1 stalled while channel 3 is fed.
    ord = 4'b1101;
    send(1'b1, 2'd1, 8'h55);
    send(1'b1, 2'd3, 8'h66);
    send(1'b0, 2'd0, 8'h00);
    check_eq("indep_ch1_hold", 32'(od4[15:8]), 32'h55);
    ord = 4'hF;
    send(1'b0, 2'd0, 8'h00);

    // Out-of-range for the 3-channel instance.
    for (int c = 0; c < 3; c++) send(1'b1, 2'd3, 8'h70 + 8'(c));
    send(1'b0, 2'd0, 8'h00);
    send(1'b0, 2'd0, 8'h00);

    // Mid-operation reset with channels 0 and 2 holding.
    ord = 4'h0;
    send(1'b1, 2'd0, 8'h0A);
    send(1'b1, 2'd2, 8'h2A);
    rst = 1'b1;
    send(1'b0, 2'd0, 8'h00);
    rst = 1'b0;
    send(1'b1, 2'd0, 8'h3C);
    ord = 4'hF;
    send(1'b0, 2'd0, 8'h00);
    send(1'b0, 2'd0, 8'h00);

    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      ord = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      send(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom));
    end
    rst = 1'b0;
    send(1'b0, 2'd0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_demux_dispatch.md
Name: stream_demux_dispatch

Overview:
- Registered 1xN stream dispatcher. Routes each accepted input word to one of N output channels, selected by the in_sel field.
- Each channel holds its word in a one-entry output register under a valid/ready handshake.
- Sits where a plain combinational 1xN demux feeds sequential consumers; adds flow control and stall tolerance per channel.

Parameters:
- N, 4, number of output channels (2..16)
- SEL_WIDTH, 2, width of in_sel; must satisfy 2**SEL_WIDTH >= N (set manually, no $clog2)
- DW, 8, data width per word

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_data  input  DW  input word
- in_sel  input  SEL_WIDTH  destination channel index
- in_valid  input  1  input word present
- in_ready  output  1  block can accept the word this cycle
- out_data  output  N*DW  channel k data at bits [k*DW +: DW]
- out_valid  output  N  per-channel word held
- out_ready  input  N  per-channel consumer ready
- drop_pulse  output  1  one-cycle pulse when a word with in_sel >= N is discarded
- drop_cnt  output  16  count of discarded words (see Optional Feature)

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_data=0, drop_pulse=0, drop_cnt=0. rst overrides all other events in that cycle. A held word mid-handshake is lost.
- Accept: transfer occurs when in_valid & in_ready at a clk edge.
- in_ready is combinational:
  - in_sel < N: in_ready = ~out_valid[in_sel] | out_ready[in_sel].
  - in_sel >= N: in_ready = 1.
- Latency: accepted word appears on channel in_sel with out_valid=1 on the cycle after acceptance (1-cycle latency).
- Channel k register update, per clk edge, in priority order:
  - load (accept with in_sel==k): out_data[k] <= in_data, out_valid[k] <= 1.
  - else if out_valid[k] & out_ready[k]: out_valid[k] <= 0; out_data[k] retains its value.
  - else: hold.
- Simultaneous drain + load on the same channel: new word replaces the old word. No bubble, no loss, because the consumer took the old word this edge.
- Stall: out_data[k] must stay stable while out_valid[k]=1 and out_ready[k]=0.
- Channels are fully independent: stalling channel j never blocks input destined for channel k != j.
- Out-of-range in_sel (>= N, possible when N is not a power of 2):
  - word is accepted and discarded; no channel changes.
  - drop_pulse=1 for exactly the following cycle.
- in_valid=0: in_ready still reflects in_sel; no state change on the input side.
- No combinational path from in_data to any output.

Optional Feature:
- Macro: STREAM_DEMUX_DROP_CNT_EN
- Defined: drop_cnt is a 16-bit register.
  - Increments by 1 on each discarded word.
  - Saturates at 16'hFFFF, no wrap.
  - Cleared by rst.
- Undefined: drop_cnt tied to 0 and no counter logic is synthesized. drop_pulse behaves identically in both builds.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=4'b0000, out_data=0, drop_cnt=0, no channel loaded.
- Sweep: out_ready=4'b1111; send in_data=8'hA0+k with in_sel=k for k=0..3 on consecutive cycles -> out_valid[k]=1 one cycle later with data 8'hA0+k; in_ready=1 throughout.
- Backpressure: out_ready[2]=0; send 8'h11 then 8'h22 to sel=2 -> first accepted; in_ready=0 while sel=2 stays presented, and 8'h11 is held stable. Raise out_ready[2] -> 8'h11 drained and 8'h22 loaded the same edge; out_valid[2] never drops.
- Independence: channel 1 stalled holding 8'h55; send 8'h66 to sel=3 -> accepted immediately; channel 1 still holds 8'h55.
- Out-of-range: N=3, SEL_WIDTH=2; send in_sel=3 three times -> in_ready=1, no out_valid change, drop_pulse high each following cycle. drop_cnt=3 with macro defined, 0 without.
- Mid-operation reset: channels 0 and 2 holding data, assert rst for one cycle -> all out_valid=0 next cycle. A subsequent send to sel=0 behaves as after power-up.
